// File: rtl/keccak_pad_buffer_pkg.sv
// pkg_keccak
// Shared constants and types for the Keccak pad buffer:
//   - sponge domain-separation suffixes (SHA3 0x06, SHAKE 0x1F)
//   - final pad byte 0x80
//   - default rate in 64-bit lanes (17 lanes = 1088-bit rate)
//   - FSM state type used by the buffer controller
package pkg_keccak;

  localparam int         DEFAULT_RATE_WORDS = 17;
  localparam logic [7:0] SUFFIX_SHA3        = 8'h06;
  localparam logic [7:0] SUFFIX_SHAKE       = 8'h1F;
  localparam logic [7:0] PAD_END            = 8'h80;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_t;

endpackage

// File: rtl/keccak_pad_buffer_pad_gen.sv
// keccak_pad_gen
// Combinational byte masking and pad insertion for a single 64-bit lane.
// Bytes 0..nbytes-1 of the input lane are kept and the rest are zeroed.
// When nbytes < 8 the suffix byte is XORed in at byte nbytes. When the lane
// is the last rate lane, 0x80 is XORed into byte 7 (giving 0x86 with the
// SHA3 suffix when both land on the same byte).
// Ports:
//   lane       in  64  raw message lane (little-endian bytes)
//   nbytes     in  4   number of message bytes to keep, 0..8
//   suffix     in  8   domain-separation suffix byte
//   final_lane in  1   lane is the last lane of the rate
//   padded     out 64  masked and padded lane
module keccak_pad_gen
  import pkg_keccak::*;
(
  input  logic [63:0] lane,
  input  logic [3:0]  nbytes,
  input  logic [7:0]  suffix,
  input  logic        final_lane,
  output logic [63:0] padded
);

  always_comb begin
    padded = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < int'(nbytes)) padded[8*b +: 8] = lane[8*b +: 8];
      if (b == int'(nbytes)) padded[8*b +: 8] = padded[8*b +: 8] ^ suffix;
    end
    if (final_lane) padded[63:56] = padded[63:56] ^ PAD_END;
  end

endmodule

// File: rtl/keccak_pad_buffer.sv
// keccak_pad_buffer
// Absorbs 64-bit message words into a rate-sized block buffer, applies
// Keccak multi-rate padding on the final word, and hands each full block to
// a permutation core using a start pulse / ready handshake.
// Optional feature: define KECCAK_SHAKE_EN to add the shake_i port, which
// selects the SHAKE suffix 0x1F instead of the SHA3 suffix 0x06.
// Ports:
//   clk           in  1     clock, rising edge
//   rst_n         in  1     asynchronous active-low reset
//   data_i        in  64    message word, little-endian bytes
//   valid_i       in  1     data_i/last_i/last_bytes_i valid
//   last_i        in  1     current word is the final message word
//   last_bytes_i  in  4     valid bytes in final word (values > 8 act as 8)
//   shake_i       in  1     SHAKE suffix select (only with KECCAK_SHAKE_EN)
//   in_ready_o    out 1     word accepted this cycle when valid_i is high
//   perm_ready_i  in  1     permutation core idle/finished
//   start_o       out 1     one-cycle permutation launch pulse
//   block_o       out 1600  padded block, lane w at bits 64w+63:64w
//   busy_o        out 1     high whenever not in FILL
//   done_o        out 1     one-cycle pulse after the final block completes
module keccak_pad_buffer
  import pkg_keccak::*;
#(
  parameter int RATE_WORDS = DEFAULT_RATE_WORDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   data_i,
  input  logic          valid_i,
  input  logic          last_i,
  input  logic [3:0]    last_bytes_i,
`ifdef KECCAK_SHAKE_EN
  input  logic          shake_i,
`endif
  output logic          in_ready_o,
  input  logic          perm_ready_i,
  output logic          start_o,
  output logic [1599:0] block_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [4:0]  LAST_W       = 5'(RATE_WORDS - 1);
  localparam logic [63:0] PAD_END_LANE = {PAD_END, 56'h0};

  state_t                      state_q, state_d;
  logic [4:0]                  wcnt_q, wcnt_d;
  logic [RATE_WORDS-1:0][63:0] lanes_q, lanes_d;
  logic                        pad_pending_q, pad_pending_d;
  logic                        final_q, final_d;

  logic        xfer, last_xfer, block_done, last_full, spill;
  logic        leave_hi, load_pad;
  logic [3:0]  nbytes;
  logic [7:0]  suffix_now, suffix_pad, suffix_aux;
  logic [4:0]  aux_idx;
  logic [63:0] lane_data, lane_aux;

  // The suffix for the current word comes straight from the input; a
  // deferred pad-only block must reuse the suffix chosen with the last word.
`ifdef KECCAK_SHAKE_EN
  logic shake_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shake_q <= 1'b0;
    end else if (last_xfer) begin
      shake_q <= shake_i;
    end
  end

  assign suffix_now = shake_i ? SUFFIX_SHAKE : SUFFIX_SHA3;
  assign suffix_pad = shake_q ? SUFFIX_SHAKE : SUFFIX_SHA3;
`else
  assign suffix_now = SUFFIX_SHA3;
  assign suffix_pad = SUFFIX_SHA3;
`endif

  assign in_ready_o = (state_q == FILL);
  assign busy_o     = (state_q != FILL);
  assign block_o    = {{(1600 - 64*RATE_WORDS){1'b0}}, lanes_q};

  assign xfer       = valid_i && in_ready_o;
  assign nbytes     = (last_bytes_i > 4'd8) ? 4'd8 : last_bytes_i;
  assign last_xfer  = xfer && last_i;
  assign block_done = xfer && (last_i || (wcnt_q == LAST_W));

  // A full final word in the last lane leaves no room for padding, so the
  // block goes out as-is and padding follows in its own block. A full final
  // word in any other lane pushes the suffix into byte 0 of the next lane.
  assign last_full  = last_xfer && (nbytes == 4'd8) && (wcnt_q == LAST_W);
  assign spill      = last_xfer && (nbytes == 4'd8) && (wcnt_q != LAST_W);

  assign leave_hi   = (state_q == WAIT_HI) && perm_ready_i;
  assign load_pad   = leave_hi && pad_pending_q;

  // The auxiliary pad lane is either the lane after a spilled final word or
  // lane 0 of the deferred pad-only block.
  assign aux_idx    = load_pad ? 5'd0 : (wcnt_q + 5'd1);
  assign suffix_aux = (state_q == FILL) ? suffix_now : suffix_pad;

  keccak_pad_gen u_pad_data (
    .lane       (data_i),
    .nbytes     (nbytes),
    .suffix     (suffix_now),
    .final_lane ((wcnt_q == LAST_W) && (nbytes != 4'd8)),
    .padded     (lane_data)
  );

  keccak_pad_gen u_pad_aux (
    .lane       (64'h0),
    .nbytes     (4'd0),
    .suffix     (suffix_aux),
    .final_lane (aux_idx == LAST_W),
    .padded     (lane_aux)
  );

  // Buffer update. Lanes beyond the current word are always zero while
  // filling (the buffer is cleared after every block), so writing the pad
  // end lane outright is equivalent to XORing 0x80 into it.
  always_comb begin
    lanes_d = lanes_q;
    for (int i = 0; i < RATE_WORDS; i++) begin
      if (leave_hi) lanes_d[i] = '0;
      if (load_pad && i == 0) lanes_d[i] = lane_aux;
      if (load_pad && i == RATE_WORDS - 1 && i != 0) lanes_d[i] = PAD_END_LANE;
      if (xfer && i == int'(wcnt_q)) lanes_d[i] = last_i ? lane_data : data_i;
      if (spill && i == int'(wcnt_q) + 1) lanes_d[i] = lane_aux;
      if (last_xfer && !last_full && i == RATE_WORDS - 1 && i != int'(wcnt_q) &&
          !(spill && i == int'(wcnt_q) + 1)) begin
        lanes_d[i] = PAD_END_LANE;
      end
    end
  end

  // Word counter, deferred-pad flag and "this block ends the message" flag.
  always_comb begin
    wcnt_d        = wcnt_q;
    pad_pending_d = pad_pending_q;
    final_d       = final_q;
    if (block_done) begin
      wcnt_d  = 5'd0;
      final_d = last_i && !last_full;
    end else if (xfer) begin
      wcnt_d = wcnt_q + 5'd1;
    end
    if (last_full) pad_pending_d = 1'b1;
    if (load_pad) begin
      pad_pending_d = 1'b0;
      final_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q       <= '0;
      wcnt_q        <= 5'd0;
      pad_pending_q <= 1'b0;
      final_q       <= 1'b0;
    end else begin
      lanes_q       <= lanes_d;
      wcnt_q        <= wcnt_d;
      pad_pending_q <= pad_pending_d;
      final_q       <= final_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake pulses. The core must drop perm_ready_i
  // (WAIT_LO) and raise it again (WAIT_HI) before the block is retired.
  always_comb begin
    state_d = state_q;
    start_o = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (block_done) state_d = ISSUE;
      end
      ISSUE: begin
        if (perm_ready_i) begin
          start_o = 1'b1;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!perm_ready_i) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (perm_ready_i) begin
          if (pad_pending_q) begin
            state_d = ISSUE;
          end else begin
            state_d = FILL;
            done_o  = final_q;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

endmodule

// File: tb/tb_keccak_pad_buffer.sv
// tb_keccak_pad_buffer
// Directed bench for keccak_pad_buffer with RATE_WORDS = 17. Inputs are
// driven 1 time unit after the rising edge and outputs are sampled on the
// falling edge. A monitor records every block presented with start_o and
// counts start_o / done_o pulses.
module tb_keccak_pad_buffer;

  logic          clk;
  logic          rst_n;
  logic [63:0]   data_i;
  logic          valid_i;
  logic          last_i;
  logic [3:0]    last_bytes_i;
  logic          in_ready_o;
  logic          perm_ready_i;
  logic          start_o;
  logic [1599:0] block_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  logic [1599:0] blk_q[$];

  keccak_pad_buffer #(.RATE_WORDS(17)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .last_i       (last_i),
    .last_bytes_i (last_bytes_i),
`ifdef KECCAK_SHAKE_EN
    .shake_i      (1'b0),
`endif
    .in_ready_o   (in_ready_o),
    .perm_ready_i (perm_ready_i),
    .start_o      (start_o),
    .block_o      (block_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Records launched blocks and pulse counts away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start_o === 1'b1) begin
        start_cnt++;
        blk_q.push_back(block_o);
      end
      if (done_o === 1'b1) done_cnt++;
    end
  end

  function automatic int first_diff(input logic [1599:0] a, input logic [1599:0] b);
    for (int i = 0; i < 25; i++) begin
      if (a[64*i +: 64] !== b[64*i +: 64]) return i;
    end
    return 0;
  endfunction

  function automatic logic [63:0] pattern_word(input int i);
    logic [7:0] v;
    v = 8'(i + 1);
    return {8{v}};
  endfunction

  // Presents one word and holds it until accepted; entered and left at the
  // drive phase (just after a rising edge).
  task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] nb);
    int guard = 0;
    data_i       = d;
    valid_i      = 1'b1;
    last_i       = l;
    last_bytes_i = nb;
    @(negedge clk);
    while (in_ready_o !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_timeout got in_ready_o=%b exp 1", in_ready_o);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  // Waits for a start_o pulse, then plays the core: ready low for
  // lo_cycles cycles, then high again, and returns after the block retires.
  task automatic do_perm(input int lo_cycles);
    int guard = 0;
    int s0;
    s0 = start_cnt;
    while (start_cnt == s0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL start_timeout got starts=%0d exp %0d", start_cnt, s0 + 1);
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    perm_ready_i = 1'b0;
    repeat (lo_cycles) begin
      @(posedge clk);
      #1;
    end
    perm_ready_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_block(input string name, input int base, input logic [1599:0] exp_blk);
    int d;
    checks++;
    if (blk_q.size() <= base) begin
      errors++;
      $display("[TB] FAIL %s got no block exp a block", name);
    end else if (blk_q[base] !== exp_blk) begin
      errors++;
      d = first_diff(blk_q[base], exp_blk);
      $display("[TB] FAIL %s lane %0d got %h exp %h", name, d,
               blk_q[base][64*d +: 64], exp_blk[64*d +: 64]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got %b exp 1", in_ready_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", busy_o); end
    checks++;
    if (start_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_start got %b exp 0", start_o); end
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got %b exp 0", done_o); end
    checks++;
    if (block_o !== '0) begin errors++; $display("[TB] FAIL rst_block got nonzero exp zero"); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_in_ready got %b exp 1", in_ready_o); end
  endtask

  task automatic test_empty;
    logic [1599:0] exp_blk;
    int base, s0, d0;
    base = blk_q.size(); s0 = start_cnt; d0 = done_cnt;
    exp_blk = '0;
    exp_blk[63:0] = 64'h06;
    exp_blk[16*64 +: 64] = 64'h8000000000000000;
    send_word(64'hDEADBEEFCAFEF00D, 1'b1, 4'd0);
    do_perm(3);
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("[TB] FAIL empty_starts got %0d exp 1", start_cnt - s0); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL empty_done got %0d exp 1", done_cnt - d0); end
    check_block("empty_block", base, exp_blk);
    @(negedge clk);
    checks++;
    if (block_o !== '0) begin errors++; $display("[TB] FAIL empty_cleared got nonzero exp zero"); end
    checks++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_idle got ready=%b busy=%b exp 1 0", in_ready_o, busy_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abc;
    logic [1599:0] exp_blk;
    int base, d0;
    base = blk_q.size(); d0 = done_cnt;
    exp_blk = '0;
    exp_blk[63:0] = 64'h0000000006636261;
    exp_blk[16*64 +: 64] = 64'h8000000000000000;
    send_word(64'hFFFFFFFFFF636261, 1'b1, 4'd3);
    do_perm(2);
    check_block("abc_block", base, exp_blk);
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL abc_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_full_136;
    logic [1599:0] exp1, exp2;
    int base, s0, d0;
    base = blk_q.size(); s0 = start_cnt; d0 = done_cnt;
    exp1 = '0;
    for (int i = 0; i < 17; i++) exp1[64*i +: 64] = pattern_word(i);
    exp2 = '0;
    exp2[63:0] = 64'h06;
    exp2[16*64 +: 64] = 64'h8000000000000000;
    for (int i = 0; i < 17; i++) send_word(pattern_word(i), (i == 16), 4'd8);
    do_perm(3);
    checks++;
    if (done_cnt - d0 != 0) begin errors++; $display("[TB] FAIL b136_early_done got %0d exp 0", done_cnt - d0); end
    do_perm(2);
    checks++;
    if (start_cnt - s0 != 2) begin errors++; $display("[TB] FAIL b136_starts got %0d exp 2", start_cnt - s0); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL b136_done got %0d exp 1", done_cnt - d0); end
    check_block("b136_block1", base, exp1);
    check_block("b136_block2", base + 1, exp2);
  endtask

  task automatic test_135;
    logic [1599:0] exp_blk;
    int base, s0;
    base = blk_q.size(); s0 = start_cnt;
    exp_blk = '0;
    for (int i = 0; i < 16; i++) exp_blk[64*i +: 64] = pattern_word(i);
    exp_blk[16*64 +: 64] = 64'h86AAAAAAAAAAAAAA;
    for (int i = 0; i < 16; i++) send_word(pattern_word(i), 1'b0, 4'd0);
    send_word(64'hAAAAAAAAAAAAAAAA, 1'b1, 4'd7);
    do_perm(2);
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("[TB] FAIL b135_starts got %0d exp 1", start_cnt - s0); end
    check_block("b135_block", base, exp_blk);
  endtask

  task automatic test_spill;
    logic [1599:0] exp_blk;
    int base, s0, d0;
    base = blk_q.size(); s0 = start_cnt; d0 = done_cnt;
    exp_blk = '0;
    exp_blk[63:0]   = 64'h1122334455667788;
    exp_blk[127:64] = 64'h99AABBCCDDEEFF00;
    exp_blk[191:128] = 64'h06;
    exp_blk[16*64 +: 64] = 64'h8000000000000000;
    send_word(64'h1122334455667788, 1'b0, 4'd0);
    send_word(64'h99AABBCCDDEEFF00, 1'b1, 4'hF);
    do_perm(2);
    checks++;
    if (start_cnt - s0 != 1 || done_cnt - d0 != 1) begin
      errors++;
      $display("[TB] FAIL spill_pulses got starts=%0d dones=%0d exp 1 1", start_cnt - s0, done_cnt - d0);
    end
    check_block("spill_block", base, exp_blk);
  endtask

  task automatic test_issue_stall;
    logic [1599:0] exp_blk;
    int base, bad;
    base = blk_q.size(); bad = 0;
    exp_blk = '0;
    exp_blk[63:0] = 64'h0000000006636261;
    exp_blk[16*64 +: 64] = 64'h8000000000000000;
    perm_ready_i = 1'b0;
    send_word(64'h0000000000636261, 1'b1, 4'd3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (start_o !== 1'b0 || in_ready_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL stall_quiet got %0d bad cycles exp 0", bad); end
    @(posedge clk);
    #1;
    perm_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (start_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_start got %b exp 1", start_o); end
    @(posedge clk);
    #1;
    perm_ready_i = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    perm_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_done got %b exp 1", done_o); end
    @(posedge clk);
    #1;
    check_block("stall_block", base, exp_blk);
  endtask

  task automatic test_reset_midway;
    logic [1599:0] exp_blk;
    int base, guard, s0;
    exp_blk = '0;
    exp_blk[63:0] = 64'h0000000006636261;
    exp_blk[16*64 +: 64] = 64'h8000000000000000;
    s0 = start_cnt; guard = 0;
    send_word(64'h0000000000636261, 1'b1, 4'd3);
    while (start_cnt == s0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    perm_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || in_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_wait_lo got busy=%b ready=%b exp 1 0", busy_o, in_ready_o);
    end
    rst_n = 1'b0;
    #3;
    checks++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0 || start_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_rst_outputs got ready=%b busy=%b start=%b done=%b exp 1 0 0 0",
               in_ready_o, busy_o, start_o, done_o);
    end
    checks++;
    if (block_o !== '0) begin errors++; $display("[TB] FAIL mid_rst_block got nonzero exp zero"); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = blk_q.size();
    send_word(64'h0000000000636261, 1'b1, 4'd3);
    do_perm(2);
    check_block("mid_rst_abc_block", base, exp_blk);
  endtask

  initial begin
    rst_n        = 1'b0;
    data_i       = '0;
    valid_i      = 1'b0;
    last_i       = 1'b0;
    last_bytes_i = '0;
    perm_ready_i = 1'b1;
    test_reset();
    test_empty();
    test_abc();
    test_full_136();
    test_135();
    test_spill();
    test_issue_stall();
    test_reset_midway();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keccak_pad_buffer.md
KECCAK_PAD_BUFFER -- requirements
Module: keccak_pad_buffer

Interface
REQ-001 Parameter: RATE_WORDS, default 17, number of 64-bit rate lanes per block (17 = 1088-bit rate); legal range 1..24.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 data_i  input  64  message word, little-endian bytes.
REQ-005 valid_i  input  1  data_i/last_i/last_bytes_i valid.
REQ-006 last_i  input  1  current word is the final message word.
REQ-007 last_bytes_i  input  4  valid bytes in final word, 0..8; ignored when last_i=0.
REQ-008 in_ready_o  output  1  buffer accepts a word this cycle.
REQ-009 perm_ready_i  input  1  permutation core idle/finished flag.
REQ-010 start_o  output  1  one-cycle pulse launching a permutation on block_o.
REQ-011 block_o  output  1600  padded block; lane w at bits 64w+63:64w; bits above 64*RATE_WORDS are 0.
REQ-012 busy_o  output  1  high in any state other than FILL.
REQ-013 done_o  output  1  one-cycle pulse when the final block's permutation completes.

Function
REQ-014 States: FILL, ISSUE, WAIT_LO, WAIT_HI; word counter wcnt 5 bits, 0..RATE_WORDS-1.
REQ-015 in_ready_o = 1 only in FILL; a word transfers when valid_i && in_ready_o.
REQ-016 On transfer, data_i is written to lane wcnt and wcnt increments.
REQ-017 Non-last transfer with wcnt = RATE_WORDS-1: block full, wcnt <= 0, go to ISSUE.
REQ-018 Last transfer: only bytes 0..last_bytes_i-1 are kept, remaining bytes of the lane are zeroed, and padding is applied in the same cycle.
REQ-019 Padding: suffix byte 0x06 XORed at first byte after message data; 0x80 XORed into byte 8*RATE_WORDS-1; if the two positions coincide the byte equals 0x86.
REQ-020 If the last transfer fills the final byte of lane RATE_WORDS-1 (last_bytes_i = 8), that block is issued unpadded and a pad_pending flag forces one extra block: all zero except the suffix at byte 0 and 0x80 at byte 8*RATE_WORDS-1.
REQ-021 A last transfer with last_bytes_i = 0 adds no data; the suffix lands at byte 0 of lane wcnt.
REQ-022 ISSUE: start_o asserted for exactly one cycle on the first cycle perm_ready_i = 1, then go to WAIT_LO.
REQ-023 WAIT_LO -> WAIT_HI when perm_ready_i = 0; WAIT_HI -> next state when perm_ready_i = 1.
REQ-024 On leaving WAIT_HI: the buffer is cleared to zero; if pad_pending, load the pad-only block and go to ISSUE; else if the issued block was final, pulse done_o and go to FILL; else go to FILL.
REQ-025 block_o is stable from the start_o cycle until the WAIT_HI exit.
REQ-026 last_bytes_i > 8 is treated as 8.

Reset
REQ-027 Asserting rst_n low in any state forces FILL, wcnt = 0, buffer = 0, pad_pending = 0, start_o = 0, done_o = 0, busy_o = 0, in_ready_o = 1 after release; any partially absorbed message is discarded.

Configuration
REQ-028 KECCAK_SHAKE_EN defined: adds input port shake_i (1 bit, sampled on the last transfer); suffix is 0x1F when shake_i = 1, else 0x06.
REQ-029 KECCAK_SHAKE_EN undefined: port shake_i is absent and the suffix is fixed at 0x06.

Structure
REQ-030 pkg_keccak holds the suffix constants (SHA3 0x06, SHAKE 0x1F), the pad-end constant 0x80, the default rate constant, and the FSM state typedef.
REQ-031 Byte masking and padding insertion are placed in the combinational sub-module keccak_pad_gen (inputs: lane, byte position, suffix, final-lane flag; output: padded lane).

Verification
REQ-032 Empty message (one word, last_i=1, last_bytes_i=0), RATE_WORDS=17 -> block_o lane0 = 0x06, lane16 = 0x8000000000000000, one start_o, done_o after the perm_ready_i 1->0->1 sequence.
REQ-033 3 bytes "abc" (data_i = 0x636261, last_bytes_i=3) -> lane0 = 0x0000000006636261, lane16 byte7 = 0x80, all other bits 0.
REQ-034 Exactly 136 bytes (17 full words, last on the 17th) -> two start_o pulses; the second block has lane0 = 0x06 and lane16 = 0x8000000000000000.
REQ-035 135 bytes (last_bytes_i=7 on the 17th word) -> single block with byte 135 = 0x86.
REQ-036 perm_ready_i held 0 for 10 cycles in ISSUE -> start_o stays 0 and in_ready_o stays 0; start_o pulses on the first cycle perm_ready_i = 1.
REQ-037 rst_n pulsed low in WAIT_LO -> all outputs return to reset values; a new "abc" message then produces the REQ-033 block.
